ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 8, byte-address width; DATA_W, default 32, word width (fixed 32, 4 byte lanes).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ifu_req_valid  in  1 / ifu_req_ready  out  1 / ifu_req_addr  in  ADDR_W: instruction-fetch read request (valid/ready).
REQ-005 ifu_rsp_valid  out  1 / ifu_rsp_data  out  32: fetch response; no backpressure.
REQ-006 lsu_req_valid  in  1 / lsu_req_ready  out  1 / lsu_req_addr  in  ADDR_W / lsu_req_we  in  1 / lsu_req_be  in  4 / lsu_req_wdata  in  32: load/store request.
REQ-007 lsu_rsp_valid  out  1 / lsu_rsp_data  out  32: load data or store ack; no backpressure.
REQ-008 ram_we  out  1 / ram_addr  out  ADDR_W / ram_din  out  32 / ram_dout  in  32: single-port RAM, 1-cycle registered read, read-first on write.

Function
REQ-009 Request transfers when valid and ready are both high at a rising edge; ready may depend combinationally on valid (grant).
REQ-010 At most one request granted per cycle; ram_addr/ram_we/ram_din driven combinationally from the granted request (or FSM in RMW_WR).
REQ-011 ram_addr = request address with bits [1:0] forced to 0; low address bits are otherwise ignored.
REQ-012 FSM states: IDLE, RMW_WR; requests accepted only in IDLE.
REQ-013 Read (ifu, or lsu with we=0) accepted cycle N: rsp_valid of that requester high in N+1 only, rsp_data = ram_dout; back-to-back reads every cycle.
REQ-014 Full store (we=1, be=4'hF) accepted N: ram_we=1 in N, ram_din=wdata; lsu_rsp_valid in N+1 (ack, data = prior word).
REQ-015 Partial store (we=1, be not 0 and not F) accepted N: read issued in N, FSM to RMW_WR; in N+1 ram_we=1, ram_din = ram_dout with lanes where be=1 replaced by wdata lanes, both readies low; lsu_rsp_valid in N+2; FSM back to IDLE in N+2.
REQ-016 Store with be=4'h0: no RAM write, treated as read for timing, ack in N+1.
REQ-017 Both valid in IDLE: lsu granted (fixed priority) unless REQ-024 applies; loser's ready low, loser holds request.
REQ-018 rsp_valid outputs are registered; rsp_data of a non-valid cycle is don't-care.
REQ-019 Address/wdata/be of a partial store captured at acceptance; requester may change inputs after handshake.

Reset
REQ-020 While rst high: both readies 0, ram_we 0, next cycle both rsp_valid 0, FSM IDLE.
REQ-021 Reset in RMW_WR cycle aborts the write (ram_we 0) and drops the pending ack.
REQ-022 Round-robin pointer (if compiled) resets to "ifu next".
REQ-023 First request accepted in the first cycle with rst low.

Configuration
REQ-024 Macro RAM_ARB_ROUND_ROBIN_EN defined: on contention grant alternates, pointer flips to the other requester after each granted contended or uncontended request; undefined: fixed lsu priority, no pointer flop.

Structure
REQ-025 Package ram_arb_pkg holds the FSM state enum, requester-id enum (REQ_IFU, REQ_LSU) and constant BE_FULL = 4'hF.
REQ-026 Sub-module ram_arb_byte_merge: combinational lane merge (old word, new word, be) -> merged word.

Verification
REQ-027 Word at 0x10 = 0xDEADBEEF; ifu read 0x10 at N -> ifu_rsp_valid N+1, data 0xDEADBEEF; ifu addr 0x13 returns same word.
REQ-028 Both valid every cycle, fixed priority, lsu reads 4 cycles -> ifu_req_ready low all 4; round-robin build -> grants alternate IFU, LSU, IFU, LSU.
REQ-029 Word 0x11223344, lsu store be=4'b0101 wdata 0xAABBCCDD -> ram_we in N+1 only, ack N+2, readback 0x11BB33DD; both readies low in N+1.
REQ-030 Full store 0xCAFEF00D then immediate read same address -> read returns 0xCAFEF00D in the cycle after read acceptance.
REQ-031 rst asserted in RMW_WR cycle -> ram_we 0, no lsu_rsp_valid, word unchanged, FSM IDLE after release.
REQ-032 be=0 store to 0x20 -> ack N+1, ram_we never high, word unchanged.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
//============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and constants for the RAM port arbiter:
//               FSM state encoding, requester identifiers, byte-enable
//               constants and a partial-store classification helper.
// Revision    : 1.0 - initial release
//============================================================================
package ram_arb_pkg;

    // Arbiter FSM: requests are only accepted in ST_IDLE; ST_RMW_WR is the
    // write-back half of a read-modify-write partial store.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } arb_state_e;

    // Requester identity (also the encoding of the round-robin pointer).
    typedef enum logic [0:0] {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

    // A store that touches some but not all byte lanes needs read-modify-write.
    function automatic logic is_partial_be(input logic [3:0] be);
        return (be != BE_NONE) && (be != BE_FULL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arb_byte_merge.sv
`default_nettype none
//============================================================================
// Module      : ram_arb_byte_merge
// Description : Combinational byte-lane merge. Each lane of the result is
//               taken from i_new_word when its byte enable is set, otherwise
//               from i_old_word.
// Ports       : i_old_word [31:0] - word currently held in RAM
//               i_new_word [31:0] - store data
//               i_be       [3:0]  - byte enables, bit n selects lane n
//               o_merged   [31:0] - merged word
// Revision    : 1.0 - initial release
//============================================================================
module ram_arb_byte_merge (
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_new_word,
    input  logic [3:0]  i_be,
    output logic [31:0] o_merged
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign o_merged[8*g +: 8] = i_be[g] ? i_new_word[8*g +: 8]
                                            : i_old_word[8*g +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
//============================================================================
// Module      : ram_port_arbiter
// Description : Arbitrates an instruction-fetch read port and a load/store
//               port onto one single-port RAM (1-cycle registered read,
//               read-first on write). Partial stores are executed as a
//               two-cycle read-modify-write.
// Config      : RAM_ARB_ROUND_ROBIN_EN - when defined, contention is resolved
//               by a round-robin pointer; otherwise the LSU has fixed priority.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               ifu_req_* / ifu_rsp_*    - fetch request (valid/ready) and
//                                          response (no backpressure)
//               lsu_req_* / lsu_rsp_*    - load/store request and response
//               ram_we/addr/din, ram_dout- RAM port
// Revision    : 1.0 - initial release
//============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rsp_data,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_we,
    input  logic [3:0]        lsu_req_be,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rsp_data,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    // Clears the byte-offset bits so the RAM only ever sees word addresses.
    localparam logic [ADDR_W-1:0] c_word_mask = {{(ADDR_W-2){1'b1}}, 2'b00};

    arb_state_e        r_state_q,         w_state_d;
    logic              r_ifu_rsp_valid_q, w_ifu_rsp_valid_d;
    logic              r_lsu_rsp_valid_q, w_lsu_rsp_valid_d;
    logic [ADDR_W-1:0] r_rmw_addr_q,      w_rmw_addr_d;
    logic [DATA_W-1:0] r_rmw_wdata_q,     w_rmw_wdata_d;
    logic [3:0]        r_rmw_be_q,        w_rmw_be_d;

    logic              w_can_accept;
    logic              w_lsu_wins;
    logic              w_ifu_fire;
    logic              w_lsu_fire;
    logic              w_lsu_partial;
    logic              w_lsu_full_wr;
    req_id_e           w_grant_id;
    logic [DATA_W-1:0] w_merged;

    //------------------------------------------------------------------------
    // Contention resolution
    //------------------------------------------------------------------------
`ifdef RAM_ARB_ROUND_ROBIN_EN
    req_id_e r_rr_ptr_q, w_rr_ptr_d;

    // Pointer names the requester favoured next; it moves to the other side
    // after every grant, contended or not.
    always_comb begin
        w_rr_ptr_d = r_rr_ptr_q;
        if (w_ifu_fire) begin
            w_rr_ptr_d = REQ_LSU;
        end else if (w_lsu_fire) begin
            w_rr_ptr_d = REQ_IFU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr_q <= REQ_IFU;
        end else begin
            r_rr_ptr_q <= w_rr_ptr_d;
        end
    end

    assign w_lsu_wins = (r_rr_ptr_q == REQ_LSU);
`else
    assign w_lsu_wins = 1'b1;
`endif

    //------------------------------------------------------------------------
    // Handshake: ready is a grant, so it depends on the other side's valid.
    //------------------------------------------------------------------------
    assign w_can_accept  = (r_state_q == ST_IDLE) && !rst;
    assign ifu_req_ready = w_can_accept && !(lsu_req_valid &&  w_lsu_wins);
    assign lsu_req_ready = w_can_accept && !(ifu_req_valid && !w_lsu_wins);
    assign w_ifu_fire    = ifu_req_valid && ifu_req_ready;
    assign w_lsu_fire    = lsu_req_valid && lsu_req_ready;
    assign w_grant_id    = w_lsu_fire ? REQ_LSU : REQ_IFU;

    assign w_lsu_partial = lsu_req_we && is_partial_be(lsu_req_be);
    assign w_lsu_full_wr = lsu_req_we && (lsu_req_be == BE_FULL);

    // During ST_RMW_WR the RAM output holds the word read at acceptance.
    ram_arb_byte_merge u_byte_merge (
        .i_old_word (ram_dout),
        .i_new_word (r_rmw_wdata_q),
        .i_be       (r_rmw_be_q),
        .o_merged   (w_merged)
    );

    //------------------------------------------------------------------------
    // Next-state, RAM drive and response generation
    //------------------------------------------------------------------------
    always_comb begin
        w_state_d         = r_state_q;
        w_ifu_rsp_valid_d = 1'b0;
        w_lsu_rsp_valid_d = 1'b0;
        w_rmw_addr_d      = r_rmw_addr_q;
        w_rmw_wdata_d     = r_rmw_wdata_q;
        w_rmw_be_d        = r_rmw_be_q;
        ram_we            = 1'b0;
        ram_addr          = ifu_req_addr & c_word_mask;
        ram_din           = lsu_req_wdata;

        case (r_state_q)
            ST_IDLE: begin
                if (w_grant_id == REQ_LSU) begin
                    ram_addr = lsu_req_addr & c_word_mask;
                end
                if (w_lsu_fire) begin
                    // Full stores write now; partial stores only read now and
                    // write back next cycle; be=0 behaves like a read.
                    ram_we = w_lsu_full_wr;
                    if (w_lsu_partial) begin
                        w_state_d     = ST_RMW_WR;
                        w_rmw_addr_d  = lsu_req_addr & c_word_mask;
                        w_rmw_wdata_d = lsu_req_wdata;
                        w_rmw_be_d    = lsu_req_be;
                    end else begin
                        w_lsu_rsp_valid_d = 1'b1;
                    end
                end else if (w_ifu_fire) begin
                    w_ifu_rsp_valid_d = 1'b1;
                end
            end
            ST_RMW_WR: begin
                // Reset in this cycle must abort the write-back.
                ram_we            = !rst;
                ram_addr          = r_rmw_addr_q;
                ram_din           = w_merged;
                w_lsu_rsp_valid_d = 1'b1;
                w_state_d         = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q         <= ST_IDLE;
            r_ifu_rsp_valid_q <= 1'b0;
            r_lsu_rsp_valid_q <= 1'b0;
            r_rmw_addr_q      <= '0;
            r_rmw_wdata_q     <= '0;
            r_rmw_be_q        <= '0;
        end else begin
            r_state_q         <= w_state_d;
            r_ifu_rsp_valid_q <= w_ifu_rsp_valid_d;
            r_lsu_rsp_valid_q <= w_lsu_rsp_valid_d;
            r_rmw_addr_q      <= w_rmw_addr_d;
            r_rmw_wdata_q     <= w_rmw_wdata_d;
            r_rmw_be_q        <= w_rmw_be_d;
        end
    end

    assign ifu_rsp_valid = r_ifu_rsp_valid_q;
    assign lsu_rsp_valid = r_lsu_rsp_valid_q;
    assign ifu_rsp_data  = ram_dout;
    assign lsu_rsp_data  = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_ram_port_arbiter
// Description : Self-checking bench for ram_port_arbiter. A behavioural RAM
//               sits on the RAM port; a transaction-level reference model
//               (word array, pending-merge record, priority pointer) predicts
//               grants, RAM writes and responses for directed and random
//               traffic.
// Revision    : 1.0 - initial release
//============================================================================
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [7:0]  ifu_req_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready;
    logic [7:0]  lsu_req_addr;
    logic        lsu_req_we;
    logic [3:0]  lsu_req_be;
    logic [31:0] lsu_req_wdata;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    ram_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_we    (lsu_req_we),
        .lsu_req_be    (lsu_req_be),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: registered read, read-first on write.
    logic [31:0] ram_mem [64];
    always @(posedge clk) begin
        ram_dout <= ram_mem[ram_addr[7:2]];
        if (ram_we) ram_mem[ram_addr[7:2]] <= ram_din;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [64];
    bit          m_busy;          // partial store awaiting its write-back cycle
    bit          m_ptr_lsu;       // round-robin: lsu favoured next
    logic [5:0]  m_word;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    bit          exp_ifu_v, exp_lsu_v, exp_ifu_chk, exp_lsu_chk;
    logic [31:0] exp_ifu_d, exp_lsu_d;
    bit          g_ifu, g_lsu;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    // One clock cycle: check responses due now, drive new inputs, check the
    // combinational grant/RAM-write decisions and advance the model.
    task automatic step(input bit iv, input logic [7:0] ia,
                        input bit lv, input logic [7:0] la, input bit lwe,
                        input logic [3:0] lbe, input logic [31:0] lwd, input bit r);
        bit lsu_first, e_ir, e_lr, e_we;
        @(negedge clk);
        check_eq("ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(exp_ifu_v));
        if (exp_ifu_v && exp_ifu_chk) check_eq("ifu_rsp_data", ifu_rsp_data, exp_ifu_d);
        check_eq("lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(exp_lsu_v));
        if (exp_lsu_v && exp_lsu_chk) check_eq("lsu_rsp_data", lsu_rsp_data, exp_lsu_d);

        rst = r;
        ifu_req_valid = iv; ifu_req_addr = ia;
        lsu_req_valid = lv; lsu_req_addr = la; lsu_req_we = lwe;
        lsu_req_be = lbe; lsu_req_wdata = lwd;
        #1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
        lsu_first = m_ptr_lsu;
`else
        lsu_first = 1'b1;
`endif
        g_ifu = 0; g_lsu = 0; e_we = 0;
        exp_ifu_v = 0; exp_lsu_v = 0; exp_ifu_chk = 0; exp_lsu_chk = 0;
        e_ir = !(lv && lsu_first);
        e_lr = !(iv && !lsu_first);

        if (r || m_busy) begin
            check_eq("ifu_ready_blocked", 32'(ifu_req_ready), 32'd0);
            check_eq("lsu_ready_blocked", 32'(lsu_req_ready), 32'd0);
        end else begin
            if (iv) check_eq("ifu_ready", 32'(ifu_req_ready), 32'(e_ir));
            if (lv) check_eq("lsu_ready", 32'(lsu_req_ready), 32'(e_lr));
        end

        if (r) begin
            m_busy = 0; m_ptr_lsu = 0;
        end else if (m_busy) begin
            e_we = 1;
            ref_mem[m_word] = merge(ref_mem[m_word], m_wd, m_be);
            exp_lsu_v = 1;
            m_busy = 0;
        end else if (lv && e_lr) begin
            g_lsu = 1; m_ptr_lsu = 0;
            if (lwe && lbe == 4'hF) begin
                e_we = 1;
                exp_lsu_v = 1; exp_lsu_chk = 1; exp_lsu_d = ref_mem[la[7:2]];
                ref_mem[la[7:2]] = lwd;
            end else if (lwe && lbe != 4'h0) begin
                m_busy = 1; m_word = la[7:2]; m_wd = lwd; m_be = lbe;
            end else begin
                exp_lsu_v = 1; exp_lsu_chk = 1; exp_lsu_d = ref_mem[la[7:2]];
            end
        end else if (iv && e_ir) begin
            g_ifu = 1; m_ptr_lsu = 1;
            exp_ifu_v = 1; exp_ifu_chk = 1; exp_ifu_d = ref_mem[ia[7:2]];
        end
        check_eq("ram_we", 32'(ram_we), 32'(e_we));
    endtask

    task automatic idle(input bit r);
        step(0, 8'h00, 0, 8'h00, 0, 4'h0, 32'h0, r);
    endtask

    bit          p_iv, p_lv, p_lwe, do_rst;
    logic [7:0]  p_ia, p_la;
    logic [3:0]  p_lbe;
    logic [31:0] p_lwd, saved;
    int          sel;

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_req_addr = 0;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_we = 0;
        lsu_req_be = 0; lsu_req_wdata = 0;
        m_busy = 0; m_ptr_lsu = 0;
        exp_ifu_v = 0; exp_lsu_v = 0; exp_ifu_chk = 0; exp_lsu_chk = 0;
        exp_ifu_d = 0; exp_lsu_d = 0;

        // Reset: readies/ram_we low, responses low afterwards.
        repeat (3) step(1, 8'h04, 1, 8'h08, 1, 4'hF, 32'h1234_5678, 1);

        // Fill every word through full stores (first one lands right after reset).
        for (int i = 0; i < 64; i++) step(0, 8'h00, 1, 8'(i * 4), 1, 4'hF, $urandom, 0);

        // Fetch of a known word, aligned and with low address bits set.
        step(0, 8'h00, 1, 8'h10, 1, 4'hF, 32'hDEAD_BEEF, 0);
        step(1, 8'h10, 0, 8'h00, 0, 4'h0, 32'h0, 0);
        step(1, 8'h13, 0, 8'h00, 0, 4'h0, 32'h0, 0);
        idle(0);

        // Contention for four cycles: lsu reads against a waiting fetch.
        repeat (4) step(1, 8'h10, 1, 8'h14, 0, 4'h0, 32'h0, 0);
        idle(0);

        // Full store followed immediately by a read of the same word.
        step(0, 8'h00, 1, 8'h24, 1, 4'hF, 32'hCAFE_F00D, 0);
        step(0, 8'h00, 1, 8'h24, 0, 4'h0, 32'h0, 0);
        idle(0);

        // Partial store via read-modify-write.
        step(0, 8'h00, 1, 8'h30, 1, 4'hF, 32'h1122_3344, 0);
        step(0, 8'h00, 1, 8'h30, 1, 4'b0101, 32'hAABB_CCDD, 0);
        step(1, 8'h00, 1, 8'h00, 0, 4'h0, 32'h0, 0);   // write-back cycle, both blocked
        idle(0);
        check_eq("rmw_word", ram_mem[12], 32'h11BB_33DD);
        step(0, 8'h00, 1, 8'h31, 0, 4'h0, 32'h0, 0);
        idle(0);

        // Reset during the write-back cycle aborts the merge.
        step(0, 8'h00, 1, 8'h34, 1, 4'hF, 32'h5566_7788, 0);
        step(0, 8'h00, 1, 8'h34, 1, 4'b0011, 32'hFFFF_FFFF, 0);
        idle(1);
        idle(0);
        check_eq("rmw_abort_word", ram_mem[13], 32'h5566_7788);
        step(0, 8'h00, 1, 8'h34, 0, 4'h0, 32'h0, 0);
        idle(0);

        // Store with no byte enables: acknowledged, memory untouched.
        saved = ram_mem[8];
        step(0, 8'h00, 1, 8'h20, 1, 4'h0, 32'h0BAD_0BAD, 0);
        idle(0);
        check_eq("be0_word", ram_mem[8], saved);

        // Random traffic; losers hold their request until granted.
        p_iv = 0; p_lv = 0; p_ia = 0; p_la = 0; p_lwe = 0; p_lbe = 0; p_lwd = 0;
        for (int c = 0; c < 500; c++) begin
            if (!p_iv && $urandom_range(0, 1) == 1) begin
                p_iv = 1; p_ia = 8'($urandom_range(0, 31));
            end
            if (!p_lv && $urandom_range(0, 1) == 1) begin
                p_lv = 1; p_la = 8'($urandom_range(0, 31));
                p_lwe = 1'($urandom_range(0, 1));
                sel = $urandom_range(0, 3);
                p_lbe = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
                p_lwd = $urandom;
            end
            do_rst = ($urandom_range(0, 63) == 0);
            step(p_iv, p_ia, p_lv, p_la, p_lwe, p_lbe, p_lwd, do_rst);
            if (g_ifu) p_iv = 0;
            if (g_lsu) p_lv = 0;
        end

        // Read back the randomly exercised words through the fetch port.
        for (int i = 0; i < 8; i++) step(1, 8'(i * 4), 0, 8'h00, 0, 4'h0, 32'h0, 0);
        idle(0);
        idle(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
